// File: rtl/cpu_mc.sv
// Multi-cycle 16-register CPU with an external ALU and handshaked instruction/data memories.
// Every instruction walks FETCH -> DECODE -> EXEC, then optionally MEM and/or WB.
module cpu_mc #(
    parameter int WIDTH_DATA = 32,
    parameter int AWIDTH     = 5,
    parameter int DWIDTH     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instruction,
    input  logic                  inst_ready,
    output logic [AWIDTH-1:0]     address_memory_inst,
    output logic                  read_inst_enable,
    input  logic [WIDTH_DATA-1:0] memory_data_in,
    input  logic                  data_ready,
    output logic [WIDTH_DATA-1:0] memory_data_out,
    output logic                  read_data_enable,
    output logic                  write_data_enable,
    output logic [DWIDTH-1:0]     address_memory_data,
    input  logic [WIDTH_DATA-1:0] result_alu,
    output logic [WIDTH_DATA-1:0] operand_a,
    output logic [WIDTH_DATA-1:0] operand_b,
    output logic [3:0]            op_ALU,
    output logic                  halted,
    output logic                  illegal_op
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ALU   = 4'd1;
    localparam logic [3:0] OP_ADDI  = 4'd2;
    localparam logic [3:0] OP_LOAD  = 4'd3;
    localparam logic [3:0] OP_STORE = 4'd4;
    localparam logic [3:0] OP_BEQ   = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_HALT  = 4'd15;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  next_state_s;
    logic [AWIDTH-1:0]       pc_r;
    logic [31:0]             ir_r;
    logic [WIDTH_DATA-1:0]   regs_r [16];
    logic [WIDTH_DATA-1:0]   wb_data_r;
    logic [DWIDTH-1:0]       mem_addr_r;
    logic [WIDTH_DATA-1:0]   mem_wdata_r;
    logic [WIDTH_DATA-1:0]   operand_a_r;
    logic [WIDTH_DATA-1:0]   operand_b_r;
    logic [3:0]              op_alu_r;
    logic                    halted_r;
    logic                    illegal_r;

    logic [3:0]              op_s;
    logic [3:0]              rd_s;
    logic [3:0]              rs1_s;
    logic [3:0]              rs2_s;
    logic [15:0]             imm_s;
    logic [WIDTH_DATA-1:0]   simm_s;
    logic [WIDTH_DATA-1:0]   rs1_val_s;
    logic [WIDTH_DATA-1:0]   rs2_val_s;
    logic [DWIDTH-1:0]       mem_addr_s;
    logic [AWIDTH-1:0]       pc_inc_s;
    logic [AWIDTH-1:0]       pc_branch_s;

    assign op_s        = ir_r[31:28];
    assign rd_s        = ir_r[27:24];
    assign rs1_s       = ir_r[23:20];
    assign rs2_s       = ir_r[19:16];
    assign imm_s       = ir_r[15:0];
    assign simm_s      = WIDTH_DATA'($signed(imm_s));
    // R0 is forced to zero on read so it never depends on the array contents
    assign rs1_val_s   = (rs1_s == 4'd0) ? {WIDTH_DATA{1'b0}} : regs_r[rs1_s];
    assign rs2_val_s   = (rs2_s == 4'd0) ? {WIDTH_DATA{1'b0}} : regs_r[rs2_s];
    assign mem_addr_s  = DWIDTH'(rs1_val_s) + DWIDTH'(simm_s);
    assign pc_inc_s    = pc_r + AWIDTH'(1'b1);
    assign pc_branch_s = pc_r + simm_s[AWIDTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (inst_ready) next_state_s = ST_DECODE;
                else            next_state_s = ST_FETCH;
            end
            ST_DECODE: next_state_s = ST_EXEC;
            ST_EXEC: begin
                case (op_s)
                    OP_ALU, OP_ADDI:   next_state_s = ST_WB;
                    OP_LOAD, OP_STORE: next_state_s = ST_MEM;
                    OP_HALT:           next_state_s = ST_HALT;
                    default:           next_state_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (!data_ready)            next_state_s = ST_MEM;
                else if (op_s == OP_LOAD)   next_state_s = ST_WB;
                else                        next_state_s = ST_FETCH;
            end
            ST_WB:   next_state_s = ST_FETCH;
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_FETCH;
        endcase
    end

    // Output decode: request strobes are pure functions of the state register
    always_comb begin
        read_inst_enable  = 1'b0;
        read_data_enable  = 1'b0;
        write_data_enable = 1'b0;
        case (state_r)
            ST_FETCH: read_inst_enable = 1'b1;
            ST_MEM: begin
                read_data_enable  = (op_s == OP_LOAD);
                write_data_enable = (op_s == OP_STORE);
            end
            default: begin
                read_inst_enable = 1'b0;
            end
        endcase
    end

    // Program counter, instruction register and sticky status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r      <= {AWIDTH{1'b0}};
            ir_r      <= 32'h0000_0000;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (inst_ready) ir_r <= instruction;
                end
                ST_EXEC: begin
                    case (op_s)
                        OP_ALU, OP_ADDI, OP_LOAD, OP_STORE: begin
                        end
                        OP_NOP:  pc_r <= pc_inc_s;
                        OP_BEQ:  pc_r <= (rs1_val_s == rs2_val_s) ? pc_branch_s : pc_inc_s;
                        OP_JMP:  pc_r <= imm_s[AWIDTH-1:0];
                        OP_HALT: halted_r <= 1'b1;
                        default: begin
                            pc_r      <= pc_inc_s;
                            illegal_r <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (data_ready && (op_s == OP_STORE)) pc_r <= pc_inc_s;
                end
                ST_WB: pc_r <= pc_inc_s;
                default: begin
                end
            endcase
        end
    end

    // Register file write port, active only in WB
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs_r[i] <= {WIDTH_DATA{1'b0}};
        end else if ((state_r == ST_WB) && (rd_s != 4'd0)) begin
            regs_r[rd_s] <= wb_data_r;
        end
    end

    // ALU operand, write-back and memory request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            operand_a_r <= {WIDTH_DATA{1'b0}};
            operand_b_r <= {WIDTH_DATA{1'b0}};
            op_alu_r    <= 4'd0;
            wb_data_r   <= {WIDTH_DATA{1'b0}};
            mem_addr_r  <= {DWIDTH{1'b0}};
            mem_wdata_r <= {WIDTH_DATA{1'b0}};
        end else begin
            case (state_r)
                ST_DECODE: begin
                    operand_a_r <= rs1_val_s;
                    operand_b_r <= (op_s == OP_ADDI) ? simm_s : rs2_val_s;
                    op_alu_r    <= (op_s == OP_ALU) ? imm_s[3:0] : 4'd0;
                end
                ST_EXEC: begin
                    if ((op_s == OP_ALU) || (op_s == OP_ADDI)) wb_data_r <= result_alu;
                    if ((op_s == OP_LOAD) || (op_s == OP_STORE)) mem_addr_r <= mem_addr_s;
                    if (op_s == OP_STORE) mem_wdata_r <= rs2_val_s;
                end
                ST_MEM: begin
                    if (data_ready && (op_s == OP_LOAD)) wb_data_r <= memory_data_in;
                end
                default: begin
                end
            endcase
        end
    end

    assign address_memory_inst = pc_r;
    assign address_memory_data = mem_addr_r;
    assign memory_data_out     = mem_wdata_r;
    assign operand_a           = operand_a_r;
    assign operand_b           = operand_b_r;
    assign op_ALU              = op_alu_r;
    assign halted              = halted_r;
    assign illegal_op          = illegal_r;

endmodule
